// File: rtl/ix_cfg_pkg.sv
// rtl/ix_cfg_pkg.sv - shared types and constants for the switch-box configuration loader
package ix_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  localparam logic CFG_SW_OPEN = 1'b0;

endpackage

// File: rtl/switch_cfg_loader_if.sv
// rtl/switch_cfg_loader_if.sv - serial config stream, status and switch-enable bus bundle
interface switch_cfg_loader_if #(
  parameter int NUM_SWITCHES = 24
);

  logic                    cfg_start;
  logic                    cfg_valid;
  logic                    cfg_bit;
  logic                    cfg_ready;
  logic                    cfg_out;
  logic                    cfg_done;
  logic                    cfg_busy;
  logic [NUM_SWITCHES-1:0] sw_en;

  modport master (
    output cfg_start, cfg_valid, cfg_bit,
    input  cfg_ready, cfg_out, cfg_done, cfg_busy, sw_en
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit,
    output cfg_ready, cfg_out, cfg_done, cfg_busy, sw_en
  );

endinterface

// File: rtl/cfg_shift_reg.sv
// rtl/cfg_shift_reg.sv - N-bit shadow shift register, MSB-first fill, parallel output
module cfg_shift_reg #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [N-1:0] shadow
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (shift_en) begin
      shadow <= {shadow[N-2:0], bit_in};
    end
  end

endmodule

// File: rtl/switch_cfg_loader.sv
// rtl/switch_cfg_loader.sv - loads a serial bitstream and atomically commits it to tranif1 enables
module switch_cfg_loader
  import ix_cfg_pkg::*;
#(
  parameter int NUM_SWITCHES = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_cfg_loader_if.slave cfg
);

  localparam int CNT_W = $clog2(NUM_SWITCHES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SWITCHES - 1);

  cfg_state_t              state;
  logic [CNT_W-1:0]        count;
  logic [NUM_SWITCHES-1:0] shadow;
  logic [NUM_SWITCHES-1:0] sw_en_q;
  logic                    done_q;
  logic                    ready;
  logic                    accept;

  assign ready  = (state == SHIFT);
  // A start in SHIFT restarts the load, so the same-cycle bit must not shift in.
  assign accept = cfg.cfg_valid & ready & ~cfg.cfg_start;

  cfg_shift_reg #(
    .N(NUM_SWITCHES)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_en(accept),
    .bit_in  (cfg.cfg_bit),
    .shadow  (shadow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      sw_en_q <= {NUM_SWITCHES{CFG_SW_OPEN}};
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state <= SHIFT;
            count <= '0;
          end
        end
        SHIFT: begin
          if (cfg.cfg_start) begin
            count <= '0;
          end else if (accept) begin
            if (count == LAST_IDX) begin
              state <= COMMIT;
              count <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          sw_en_q <= shadow;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_busy  = (state != IDLE);
  assign cfg.cfg_out   = shadow[NUM_SWITCHES-1];
  assign cfg.cfg_done  = done_q;
  assign cfg.sw_en     = sw_en_q;

endmodule
